// File: rtl/core_run_ctrl_pkg.sv
// Shared types and default sizes for the CORE run controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package core_run_ctrl_pkg;

    // Default geometry: 16-word instruction memory, 32-bit words, 16-bit run budget.
    localparam int IMW_DEF = 4;
    localparam int IW_DEF  = 32;
    localparam int TOW_DEF = 16;

    // Controller states. The encoding is fixed here so that every user agrees on it.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ARMED = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4,
        S_TOUT  = 3'd5
    } state_t;

endpackage

// File: rtl/core_run_ctrl_run_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Latency: count updates on the clock edge after clr/en are sampled.
// Backpressure: none; clr wins over en, and the count sticks at all-ones.
module run_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] ALL_ONE = {W{1'b1}};

    // Clear has priority; otherwise count up while enabled, holding at the maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != ALL_ONE)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/core_run_ctrl.sv
// Streams a program into CORE's instruction memory, then launches and times a CORE run.
// Latency: memory write appears one cycle after the loader handshake; core_start follows state.
// Backpressure: ld_ready drops outside IDLE/LOAD (and during abort); pending words are held off, not dropped.
module core_run_ctrl
    import core_run_ctrl_pkg::*;
#(
    parameter int IMW = IMW_DEF,
    parameter int IW  = IW_DEF,
    parameter int TOW = TOW_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ld_valid,
    input  logic [IW-1:0]  ld_data,
    input  logic           ld_last,
    output logic           ld_ready,
    output logic           im_we,
    output logic [IMW-1:0] im_addr,
    output logic [IW-1:0]  im_wdata,
    input  logic           go,
    input  logic           abort,
    input  logic [TOW-1:0] max_cycles,
    input  logic           core_halt,
    output logic           core_start,
    output logic           busy,
    output logic           done,
    output logic           timeout,
    output logic           overflow,
    output logic [IMW:0]   word_count,
    output logic [TOW-1:0] cycle_count
);

    localparam logic [IMW-1:0] PTR_ONE  = {{(IMW-1){1'b0}}, 1'b1};
    localparam logic [IMW-1:0] PTR_LAST = {IMW{1'b1}};
    localparam logic [IMW:0]   WC_ONE   = {{IMW{1'b0}}, 1'b1};
    localparam logic [TOW-1:0] CYC_ONE  = {{(TOW-1){1'b0}}, 1'b1};

    state_t         state;
    state_t         state_nxt;
    logic [IMW-1:0] ptr;
    logic           accept;
    logic           launch;
    logic           run_stay;
    logic           ptr_at_end;
    logic           budget_hit;

    // A handshake only ever happens in IDLE/LOAD, and never in an abort cycle.
    assign accept     = ld_valid & ld_ready;
    assign ptr_at_end = (ptr == PTR_LAST);

    // Budget of zero means unlimited; otherwise the last permitted RUN cycle is max_cycles-1.
    assign budget_hit = (max_cycles != '0) && (cycle_count == (max_cycles - CYC_ONE));

    // State register; async reset returns to IDLE, which also drops core_start immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-state strobes; abort overrides every other transition.
    always_comb begin
        state_nxt  = state;
        ld_ready   = 1'b0;
        core_start = 1'b0;
        launch     = 1'b0;
        run_stay   = 1'b0;
        case (state)
            S_IDLE: begin
                ld_ready = ~abort;
                if (ld_valid) begin
                    state_nxt = ld_last ? S_ARMED : S_LOAD;
                end
            end
            S_LOAD: begin
                ld_ready = ~abort;
                if (ld_valid && (ld_last || ptr_at_end)) begin
                    state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                if (go) begin
                    state_nxt = S_RUN;
                    launch    = 1'b1;
                end
            end
            S_RUN: begin
                core_start = ~abort;
                if (core_halt) begin
                    state_nxt = S_DONE;
                end else if (budget_hit) begin
                    state_nxt = S_TOUT;
                end else begin
                    run_stay = 1'b1;
                end
            end
            S_DONE, S_TOUT: begin
                if (go) begin
                    state_nxt = S_RUN;
                    launch    = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (abort) begin
            state_nxt = S_IDLE;
            launch    = 1'b0;
            run_stay  = 1'b0;
        end
    end

    // Load pointer, word count and sticky overflow; the first word of a load restarts them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
        end else if (abort) begin
            ptr        <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
        end else if (accept) begin
            if (state == S_IDLE) begin
                ptr        <= PTR_ONE;
                word_count <= WC_ONE;
                overflow   <= 1'b0;
            end else begin
                ptr        <= ptr + PTR_ONE;
                word_count <= word_count + WC_ONE;
                if (!ld_last && ptr_at_end) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    // Registered memory write port: one-cycle write strobe after each accepted word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= '0;
        end else if (abort) begin
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= '0;
        end else begin
            im_we <= accept;
            if (accept) begin
                im_addr  <= (state == S_IDLE) ? '0 : ptr;
                im_wdata <= ld_data;
            end
        end
    end

    // Run timer: cleared on launch and abort, advances only on RUN cycles that stay in RUN,
    // so the value seen on the last RUN cycle is what DONE/TOUT report.
    run_counter #(
        .W (TOW)
    ) u_run_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (launch | abort),
        .en    (run_stay),
        .count (cycle_count)
    );

    assign busy    = (state == S_LOAD) || (state == S_RUN);
    assign done    = (state == S_DONE);
    assign timeout = (state == S_TOUT);

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: directed vector table, hand sequences for corner cases, random soak.
// Latency: n/a.
// Backpressure: n/a.
module tb_core_run_ctrl;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_data = '0;
    logic        ld_last = 1'b0;
    logic        go = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] max_cycles = '0;
    logic        core_halt = 1'b0;
    logic        ld_ready, im_we, core_start, busy, done, timeout, overflow;
    logic [3:0]  im_addr;
    logic [31:0] im_wdata;
    logic [4:0]  word_count;
    logic [15:0] cycle_count;

    int n_chk = 0;
    int n_fail = 0;

    core_run_ctrl #(.IMW(4), .IW(32), .TOW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .go(go), .abort(abort), .max_cycles(max_cycles), .core_halt(core_halt),
        .core_start(core_start), .busy(busy), .done(done), .timeout(timeout),
        .overflow(overflow), .word_count(word_count), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (phase + counters, updated once per clock) ----------
    localparam int P_IDLE = 0, P_LOAD = 1, P_ARMED = 2, P_RUN = 3, P_DONE = 4, P_TOUT = 5;
    int ph, m_ptr, m_wc, m_cyc, m_addr;
    bit m_ovf, m_we;
    logic [31:0] m_wd;

    task automatic model_reset();
        ph = P_IDLE; m_ptr = 0; m_wc = 0; m_cyc = 0; m_ovf = 0;
        m_we = 0; m_addr = 0; m_wd = '0;
    endtask

    task automatic model_check();
        if (!abort) chk("ld_ready", ld_ready, (ph == P_IDLE || ph == P_LOAD));
        chk("core_start", core_start, (ph == P_RUN) && !abort);
        chk("busy", busy, (ph == P_LOAD || ph == P_RUN));
        chk("done", done, ph == P_DONE);
        chk("timeout", timeout, ph == P_TOUT);
        chk("im_we", im_we, m_we);
        if (m_we) begin
            chk("im_addr", im_addr, m_addr);
            chk("im_wdata", im_wdata, m_wd);
        end
        chk("overflow", overflow, m_ovf);
        chk("word_count", word_count, m_wc);
        chk("cycle_count", cycle_count, m_cyc);
    endtask

    task automatic model_step();
        bit acc;
        if (!rst_n || abort) begin
            model_reset();
        end else begin
            acc = ld_valid && (ph == P_IDLE || ph == P_LOAD);
            m_we = acc;
            if (acc) begin
                m_addr = (ph == P_IDLE) ? 0 : m_ptr;
                m_wd = ld_data;
            end
            case (ph)
                P_IDLE: if (acc) begin
                    m_ptr = 1; m_wc = 1; m_ovf = 0;
                    ph = ld_last ? P_ARMED : P_LOAD;
                end
                P_LOAD: if (acc) begin
                    m_wc++;
                    if (ld_last) ph = P_ARMED;
                    else if (m_ptr == DEPTH - 1) begin m_ovf = 1; ph = P_ARMED; end
                    m_ptr = (m_ptr + 1) % DEPTH;
                end
                P_RUN: begin
                    if (core_halt) ph = P_DONE;
                    else if (max_cycles != 0 && m_cyc == int'(max_cycles) - 1) ph = P_TOUT;
                    else if (m_cyc < 65535) m_cyc++;
                end
                default: if (go) begin ph = P_RUN; m_cyc = 0; end
            endcase
        end
    endtask

    // sample: compare at the falling edge; advance: move the model across the rising edge.
    task automatic sample();
        @(negedge clk);
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic v; logic [31:0] d; logic l; logic g; logic a; logic [15:0] mx; logic h;
        logic e_rdy; logic e_we; logic [3:0] e_addr; logic [31:0] e_wd;
        logic e_start; logic e_busy; logic e_done; logic e_tout;
        logic [4:0] e_wc; logic [15:0] e_cyc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic [31:0] d, input logic l,
                                input logic g, input logic a, input logic [15:0] mx,
                                input logic h, input logic rdy, input logic we,
                                input logic [3:0] addr, input logic [31:0] wd,
                                input logic st, input logic bz, input logic dn,
                                input logic to, input logic [4:0] wc, input logic [15:0] cy);
        vec_t r;
        r.v = v; r.d = d; r.l = l; r.g = g; r.a = a; r.mx = mx; r.h = h;
        r.e_rdy = rdy; r.e_we = we; r.e_addr = addr; r.e_wd = wd;
        r.e_start = st; r.e_busy = bz; r.e_done = dn; r.e_tout = to;
        r.e_wc = wc; r.e_cyc = cy;
        return r;
    endfunction

    initial begin
        // load A0..A2, stray word held off in ARMED, run to halt at cycle 7, then budget of 5
        tbl.push_back(mk(1, 32'hA0, 0, 0, 0, 0, 0,  1, 0, 0, 0,      0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'hA1, 0, 0, 0, 0, 0,  1, 1, 0, 32'hA0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 32'hA2, 1, 0, 0, 0, 0,  1, 1, 1, 32'hA1, 0, 1, 0, 0, 2, 0));
        tbl.push_back(mk(0, 0,      0, 0, 0, 0, 0,  0, 1, 2, 32'hA2, 0, 0, 0, 0, 3, 0));
        tbl.push_back(mk(1, 32'hB0, 0, 0, 0, 0, 0,  0, 0, 0, 0,      0, 0, 0, 0, 3, 0));
        tbl.push_back(mk(0, 0,      0, 1, 0, 0, 0,  0, 0, 0, 0,      0, 0, 0, 0, 3, 0));
        for (int k = 0; k < 7; k++)
            tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 1, 0, 0, 3, 16'(k)));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,       0, 0, 0, 0, 1, 1, 0, 0, 3, 7));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 1, 0, 3, 7));
        tbl.push_back(mk(0, 0, 0, 1, 0, 5, 0,       0, 0, 0, 0, 0, 0, 1, 0, 3, 7));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(0, 0, 0, 0, 0, 5, 0,   0, 0, 0, 0, 1, 1, 0, 0, 3, 16'(k)));
        tbl.push_back(mk(0, 0, 0, 0, 0, 5, 0,       0, 0, 0, 0, 0, 0, 0, 1, 3, 4));

        // reset state
        model_reset();
        cyc();
        sample();
        chk("rst_ld_ready", ld_ready, 1);
        chk("rst_core_start", core_start, 0);
        chk("rst_im_we", im_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_word_count", word_count, 0);
        chk("rst_cycle_count", cycle_count, 0);
        advance();
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t r;
            r = tbl[i];
            ld_valid = r.v; ld_data = r.d; ld_last = r.l; go = r.g; abort = r.a;
            max_cycles = r.mx; core_halt = r.h;
            sample();
            chk($sformatf("tbl_rdy[%0d]", i), ld_ready, r.e_rdy);
            chk($sformatf("tbl_we[%0d]", i), im_we, r.e_we);
            if (r.e_we) begin
                chk($sformatf("tbl_addr[%0d]", i), im_addr, r.e_addr);
                chk($sformatf("tbl_wdata[%0d]", i), im_wdata, r.e_wd);
            end
            chk($sformatf("tbl_start[%0d]", i), core_start, r.e_start);
            chk($sformatf("tbl_busy[%0d]", i), busy, r.e_busy);
            chk($sformatf("tbl_done[%0d]", i), done, r.e_done);
            chk($sformatf("tbl_tout[%0d]", i), timeout, r.e_tout);
            chk($sformatf("tbl_ovf[%0d]", i), overflow, 0);
            chk($sformatf("tbl_wc[%0d]", i), word_count, r.e_wc);
            chk($sformatf("tbl_cyc[%0d]", i), cycle_count, r.e_cyc);
            advance();
        end

        // halt and budget expiry coincide: halt wins
        ld_valid = 0; go = 1; max_cycles = 3; core_halt = 0;
        cyc();
        go = 0;
        cyc();
        cyc();
        core_halt = 1;
        cyc();
        core_halt = 0;
        sample();
        chk("tie_done", done, 1);
        chk("tie_timeout", timeout, 0);
        chk("tie_cycle_count", cycle_count, 2);
        chk("tie_core_start", core_start, 0);
        advance();

        // abort returns every output to its reset value
        abort = 1;
        cyc();
        abort = 0; max_cycles = 0;
        sample();
        chk("abort_ld_ready", ld_ready, 1);
        chk("abort_im_we", im_we, 0);
        chk("abort_im_addr", im_addr, 0);
        chk("abort_im_wdata", im_wdata, 0);
        chk("abort_core_start", core_start, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_timeout", timeout, 0);
        chk("abort_overflow", overflow, 0);
        chk("abort_word_count", word_count, 0);
        chk("abort_cycle_count", cycle_count, 0);
        advance();

        // 16 words without ld_last: full memory written, overflow, 17th word held off
        for (int i = 0; i <= DEPTH; i++) begin
            ld_valid = 1; ld_last = 0; ld_data = 32'hC0 + 32'(i);
            sample();
            if (i > 0) begin
                chk($sformatf("ovf_we[%0d]", i), im_we, 1);
                chk($sformatf("ovf_addr[%0d]", i), im_addr, 64'(i - 1));
                chk($sformatf("ovf_wdata[%0d]", i), im_wdata, 64'(32'hC0 + 32'(i - 1)));
            end
            chk($sformatf("ovf_rdy[%0d]", i), ld_ready, (i < DEPTH));
            advance();
        end
        sample();
        chk("ovf_17th_we", im_we, 0);
        chk("ovf_flag", overflow, 1);
        chk("ovf_word_count", word_count, 16);
        chk("ovf_ld_ready", ld_ready, 0);
        advance();
        ld_valid = 0;

        // reset asserted in the middle of a run
        go = 1;
        cyc();
        go = 0;
        repeat (3) cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("rstrun_core_start", core_start, 0);
        chk("rstrun_busy", busy, 0);
        model_reset();
        repeat (2) cyc();
        rst_n = 1'b1;
        sample();
        chk("rstrun_ld_ready", ld_ready, 1);
        chk("rstrun_im_we", im_we, 0);
        advance();
        sample();
        chk("rstrun_im_we_late", im_we, 0);
        advance();

        // random soak against the model
        for (int n = 0; n < 3000; n++) begin
            ld_valid   = 1'($urandom_range(0, 1));
            ld_data    = $urandom;
            ld_last    = ($urandom_range(0, 9) == 0);
            go         = ($urandom_range(0, 3) == 0);
            abort      = ($urandom_range(0, 39) == 0);
            core_halt  = ($urandom_range(0, 7) == 0);
            max_cycles = 16'($urandom_range(0, 6));
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
